// File: rtl/bird_pkg.sv
// Shared definitions for the bird controller: game states, default physics
// constants and the UART key codes used when BIRD_UART_FLAP_EN is defined.
package bird_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    localparam int unsigned DEF_HMAX      = 800;
    localparam int unsigned DEF_VMAX      = 525;
    localparam int unsigned DEF_V_ACTIVE  = 480;
    localparam int unsigned DEF_BIRD_X    = 100;
    localparam int unsigned DEF_BIRD_SIZE = 16;
    localparam int unsigned DEF_START_Y   = 232;
    localparam int unsigned DEF_GRAVITY   = 1;
    localparam int unsigned DEF_FLAP_VEL  = 6;
    localparam int unsigned DEF_VEL_MAX   = 8;
    localparam int unsigned DEF_Y_W       = 10;

    localparam logic [7:0] KEY_FLAP  = 8'h20;
    localparam logic [7:0] KEY_START = 8'h0D;

endpackage

// File: rtl/bird_ctrl_core_if.sv
// Bundle of the bird controller's video-timing, control and status signals.
// master drives the counts and pulses; slave is the controller side.
interface bird_ctrl_if #(
    parameter int unsigned H_W = 10,
    parameter int unsigned V_W = 10,
    parameter int unsigned Y_W = 10
);
    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;
    logic           frame_start;
    logic           start;
    logic           flap;
    logic           draw_bird;
    logic [Y_W-1:0] bird_y;
    logic [1:0]     state;
    logic           dead;
    logic [7:0]     flap_count;

    modport master (
        output h_count, v_count, frame_start, start, flap,
        input  draw_bird, bird_y, state, dead, flap_count
    );

    modport slave (
        input  h_count, v_count, frame_start, start, flap,
        output draw_bird, bird_y, state, dead, flap_count
    );
endinterface

// File: rtl/bird_physics.sv
// Per-frame bird physics: gravity or flap impulse, terminal-velocity clamp,
// position update and ceiling/floor clamp with a hit flag.
module bird_physics #(
    parameter int unsigned Y_W       = 10,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned BIRD_SIZE = 16,
    parameter int unsigned GRAVITY   = 1,
    parameter int unsigned FLAP_VEL  = 6,
    parameter int unsigned VEL_MAX   = 8
) (
    input  logic                  flap,
    input  logic [Y_W-1:0]        y,
    input  logic signed [Y_W-1:0] vel,
    output logic signed [Y_W-1:0] vel_next,
    output logic [Y_W-1:0]        y_next,
    output logic                  hit
);
    localparam int unsigned S_W = Y_W + 1;
    localparam logic signed [S_W-1:0] GRAV_S    = S_W'(GRAVITY);
    localparam logic signed [S_W-1:0] VEL_MAX_S = S_W'(VEL_MAX);
    localparam logic signed [S_W-1:0] FLAP_S    = -(S_W'(FLAP_VEL));
    localparam logic signed [S_W-1:0] FLOOR_S   = S_W'(V_ACTIVE - BIRD_SIZE);

    logic signed [S_W-1:0] vel_ext;
    logic signed [S_W-1:0] vel_inc;
    logic signed [S_W-1:0] vel_new;
    logic signed [S_W-1:0] y_sum;

    always_comb begin
        vel_ext = {vel[Y_W-1], vel};
        vel_inc = vel_ext + GRAV_S;
        if (flap) begin
            vel_new = FLAP_S;
        end else if (vel_inc > VEL_MAX_S) begin
            vel_new = VEL_MAX_S;
        end else begin
            vel_new = vel_inc;
        end

        // Sum in one extra signed bit so a rise past row 0 shows up negative.
        y_sum    = $signed({1'b0, y}) + vel_new;
        vel_next = vel_new[Y_W-1:0];
        hit      = 1'b0;
        y_next   = y_sum[Y_W-1:0];
        if (y_sum < 0) begin
            y_next = '0;
            hit    = 1'b1;
        end else if (y_sum > FLOOR_S) begin
            y_next = Y_W'(V_ACTIVE - BIRD_SIZE);
            hit    = 1'b1;
        end
    end

endmodule

// File: rtl/bird_ctrl_core.sv
// Bird controller: IDLE/PLAY/DEAD game FSM, per-frame position/velocity
// registers and the registered bird draw signal. Option: BIRD_UART_FLAP_EN.
module bird_ctrl_core
    import bird_pkg::*;
#(
    parameter int unsigned HMAX      = DEF_HMAX,
    parameter int unsigned VMAX      = DEF_VMAX,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned BIRD_X    = DEF_BIRD_X,
    parameter int unsigned BIRD_SIZE = DEF_BIRD_SIZE,
    parameter int unsigned START_Y   = DEF_START_Y,
    parameter int unsigned GRAVITY   = DEF_GRAVITY,
    parameter int unsigned FLAP_VEL  = DEF_FLAP_VEL,
    parameter int unsigned VEL_MAX   = DEF_VEL_MAX,
    parameter int unsigned Y_W       = DEF_Y_W
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset_n,
    input  logic [$clog2(HMAX)-1:0] i_H_count,
    input  logic [$clog2(VMAX)-1:0] i_V_count,
    input  logic                    i_Frame_start,
    input  logic                    i_Start,
    input  logic                    i_Flap,
`ifdef BIRD_UART_FLAP_EN
    input  logic                    i_RX_DV,
    input  logic [7:0]              i_RX_Byte,
`endif
    output logic                    o_Draw_Bird,
    output logic [Y_W-1:0]          o_Bird_Y,
    output logic [1:0]              o_State,
    output logic                    o_Dead,
    output logic [7:0]              o_Flap_Count
);
    localparam int unsigned C_W = 16;

    state_e                state_q, state_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [Y_W-1:0] vel_q, vel_d;
    logic                  flap_pend_q, flap_pend_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  draw_q, draw_d;
    logic                  dead_q, dead_d;

    logic                  start_c;
    logic                  flap_c;
    logic                  flap_eff_c;
    logic signed [Y_W-1:0] phys_vel_c;
    logic [Y_W-1:0]        phys_y_c;
    logic                  phys_hit_c;
    logic [C_W-1:0]        h_ext_c, v_ext_c, y_ext_c;
    logic                  in_box_c;

`ifdef BIRD_UART_FLAP_EN
    assign start_c = i_Start | (i_RX_DV && (i_RX_Byte == KEY_START));
    assign flap_c  = i_Flap  | (i_RX_DV && (i_RX_Byte == KEY_FLAP));
`else
    assign start_c = i_Start;
    assign flap_c  = i_Flap;
`endif

    // A flap arriving on the tick itself still counts for that tick.
    assign flap_eff_c = flap_pend_q | flap_c;

    bird_physics #(
        .Y_W      (Y_W),
        .V_ACTIVE (V_ACTIVE),
        .BIRD_SIZE(BIRD_SIZE),
        .GRAVITY  (GRAVITY),
        .FLAP_VEL (FLAP_VEL),
        .VEL_MAX  (VEL_MAX)
    ) u_physics (
        .flap    (flap_eff_c),
        .y       (y_q),
        .vel     (vel_q),
        .vel_next(phys_vel_c),
        .y_next  (phys_y_c),
        .hit     (phys_hit_c)
    );

    always_comb begin
        h_ext_c  = C_W'(i_H_count);
        v_ext_c  = C_W'(i_V_count);
        y_ext_c  = C_W'(y_q);
        in_box_c = (h_ext_c >= C_W'(BIRD_X)) &&
                   (h_ext_c <  C_W'(BIRD_X + BIRD_SIZE)) &&
                   (v_ext_c >= y_ext_c) &&
                   (v_ext_c <  y_ext_c + C_W'(BIRD_SIZE));
    end

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        vel_d       = vel_q;
        flap_pend_d = flap_pend_q;
        cnt_d       = cnt_q;
        draw_d      = in_box_c;

        unique case (state_q)
            ST_IDLE: begin
                y_d         = Y_W'(START_Y);
                vel_d       = '0;
                flap_pend_d = 1'b0;
                if (start_c) begin
                    state_d = ST_PLAY;
                    cnt_d   = '0;
                end
            end
            ST_PLAY: begin
                if (i_Frame_start) begin
                    y_d         = phys_y_c;
                    vel_d       = phys_vel_c;
                    flap_pend_d = 1'b0;
                    if (flap_eff_c && (cnt_q != 8'hFF)) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (phys_hit_c) begin
                        state_d = ST_DEAD;
                    end
                end else if (flap_c) begin
                    flap_pend_d = 1'b1;
                end
            end
            ST_DEAD: begin
                flap_pend_d = 1'b0;
                if (start_c) begin
                    state_d = ST_IDLE;
                    y_d     = Y_W'(START_Y);
                    vel_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        dead_d = (state_d == ST_DEAD);
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= ST_IDLE;
            y_q         <= Y_W'(START_Y);
            vel_q       <= '0;
            flap_pend_q <= 1'b0;
            cnt_q       <= '0;
            draw_q      <= 1'b0;
            dead_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            flap_pend_q <= flap_pend_d;
            cnt_q       <= cnt_d;
            draw_q      <= draw_d;
            dead_q      <= dead_d;
        end
    end

    assign o_Draw_Bird  = draw_q;
    assign o_Bird_Y     = y_q;
    assign o_State      = state_q;
    assign o_Dead       = dead_q;
    assign o_Flap_Count = cnt_q;

endmodule

// File: tb/tb_bird_ctrl_core.sv
// Directed bench for bird_ctrl_core: a frame-level game model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_bird_ctrl_core;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   check_en = 1'b0;

    bird_ctrl_if #(.H_W(10), .V_W(10), .Y_W(10)) bif ();

    bird_ctrl_core dut (
        .i_Clk        (clk),
        .i_Reset_n    (rst_n),
        .i_H_count    (bif.h_count),
        .i_V_count    (bif.v_count),
        .i_Frame_start(bif.frame_start),
        .i_Start      (bif.start),
        .i_Flap       (bif.flap),
`ifdef BIRD_UART_FLAP_EN
        .i_RX_DV      (1'b0),
        .i_RX_Byte    (8'h00),
`endif
        .o_Draw_Bird  (bif.draw_bird),
        .o_Bird_Y     (bif.bird_y),
        .o_State      (bif.state),
        .o_Dead       (bif.dead),
        .o_Flap_Count (bif.flap_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Game model: state 0/1/2, integer position and velocity.
    int m_state = 0;
    int m_y     = 232;
    int m_vel   = 0;
    int m_pend  = 0;
    int m_cnt   = 0;
    int m_draw  = 0;

    always @(posedge clk or negedge rst_n) begin
        int ny;
        int h;
        int v;
        if (!rst_n) begin
            m_state = 0; m_y = 232; m_vel = 0; m_pend = 0; m_cnt = 0; m_draw = 0;
        end else begin
            h = int'(bif.h_count);
            v = int'(bif.v_count);
            m_draw = (h >= 100 && h < 116 && v >= m_y && v < m_y + 16) ? 1 : 0;
            if (m_state == 0) begin
                m_pend = 0;
                if (bif.start) begin
                    m_state = 1;
                    m_cnt   = 0;
                end
            end else if (m_state == 1) begin
                if (bif.frame_start) begin
                    if (m_pend == 1 || bif.flap) begin
                        m_vel = -6;
                        if (m_cnt < 255) m_cnt = m_cnt + 1;
                    end else begin
                        m_vel = (m_vel + 1 > 8) ? 8 : m_vel + 1;
                    end
                    m_pend = 0;
                    ny = m_y + m_vel;
                    if (ny < 0) begin
                        m_y = 0; m_state = 2;
                    end else if (ny > 464) begin
                        m_y = 464; m_state = 2;
                    end else begin
                        m_y = ny;
                    end
                end else if (bif.flap) begin
                    m_pend = 1;
                end
            end else begin
                if (bif.start) begin
                    m_state = 0; m_y = 232; m_vel = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_state", 32'(bif.state), m_state);
            chk("model_y", 32'(bif.bird_y), m_y);
            chk("model_dead", 32'(bif.dead), (m_state == 2) ? 1 : 0);
            chk("model_cnt", 32'(bif.flap_count), m_cnt);
            chk("model_draw", 32'(bif.draw_bird), m_draw);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        bif.start = 1'b1; cyc(); bif.start = 1'b0;
    endtask

    task automatic pulse_flap();
        bif.flap = 1'b1; cyc(); bif.flap = 1'b0;
    endtask

    task automatic frame();
        bif.frame_start = 1'b1; cyc(); bif.frame_start = 1'b0;
        cyc();
    endtask

    task automatic draw_at(input int h, input int v, input int exp, input string name);
        bif.h_count = 10'(h);
        bif.v_count = 10'(v);
        cyc();
        chk(name, 32'(bif.draw_bird), exp);
        bif.h_count = '0;
        bif.v_count = '0;
    endtask

    initial begin
        int k;
        rst_n           = 1'b1;
        bif.h_count     = '0;
        bif.v_count     = '0;
        bif.frame_start = 1'b0;
        bif.start       = 1'b0;
        bif.flap        = 1'b0;
        #1 rst_n = 1'b0;
        check_en = 1'b1;
        cyc(); cyc();
        chk("rst_state", 32'(bif.state), 0);
        chk("rst_y", 32'(bif.bird_y), 232);
        chk("rst_dead", 32'(bif.dead), 0);
        chk("rst_cnt", 32'(bif.flap_count), 0);
        chk("rst_draw", 32'(bif.draw_bird), 0);
        rst_n = 1'b1;
        cyc();

        // Flap ignored in IDLE, then start and three gravity frames.
        pulse_flap();
        pulse_start();
        chk("start_state", 32'(bif.state), 1);
        frame(); chk("grav_y1", 32'(bif.bird_y), 233);
        frame(); chk("grav_y2", 32'(bif.bird_y), 235);
        frame(); chk("grav_y3", 32'(bif.bird_y), 238);
        chk("grav_cnt", 32'(bif.flap_count), 0);

        // Asynchronous reset mid-PLAY, observed without a clock edge.
        @(posedge clk); #7;
        rst_n = 1'b0;
        #1;
        chk("async_state", 32'(bif.state), 0);
        chk("async_y", 32'(bif.bird_y), 232);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single flap from rest, then three pulses in one frame.
        pulse_start();
        pulse_flap();
        frame();
        chk("flap_y", 32'(bif.bird_y), 226);
        chk("flap_cnt", 32'(bif.flap_count), 1);
        pulse_flap(); pulse_flap(); pulse_flap();
        frame();
        chk("multi_cnt", 32'(bif.flap_count), 2);
        chk("multi_y", 32'(bif.bird_y), 220);

        // Flap coincident with the tick applies to that tick.
        bif.frame_start = 1'b1; bif.flap = 1'b1;
        cyc();
        bif.frame_start = 1'b0; bif.flap = 1'b0;
        chk("coin_y", 32'(bif.bird_y), 214);
        chk("coin_cnt", 32'(bif.flap_count), 3);

        // Start is ignored during PLAY.
        pulse_start();
        chk("play_start_ign", 32'(bif.state), 1);

        // Fall to the floor.
        k = 0;
        while (bif.dead !== 1'b1 && k < 60) begin
            frame();
            k++;
        end
        if (k >= 60) begin
            n_checks++; n_errors++;
            $display("FAIL floor_timeout: got no DEAD after %0d frames expected DEAD", k);
        end
        chk("floor_y", 32'(bif.bird_y), 464);
        chk("floor_dead", 32'(bif.dead), 1);
        pulse_flap();
        frame(); frame(); frame();
        chk("floor_hold_y", 32'(bif.bird_y), 464);
        chk("dead_flap_cnt", 32'(bif.flap_count), 3);

        // Restart, then start coincident with a frame tick.
        pulse_start();
        chk("restart_state", 32'(bif.state), 0);
        chk("restart_y", 32'(bif.bird_y), 232);
        chk("idle_keeps_cnt", 32'(bif.flap_count), 3);
        bif.start = 1'b1; bif.frame_start = 1'b1;
        cyc();
        bif.start = 1'b0; bif.frame_start = 1'b0;
        chk("coin_start_state", 32'(bif.state), 1);
        chk("coin_start_y", 32'(bif.bird_y), 232);
        chk("new_game_cnt", 32'(bif.flap_count), 0);

        // Draw window at y=232.
        draw_at(100, 232, 1, "draw_tl");
        draw_at(116, 232, 0, "draw_right");
        draw_at(100, 247, 1, "draw_bl");
        draw_at(99, 232, 0, "draw_left");
        draw_at(115, 248, 0, "draw_below");
        draw_at(115, 231, 0, "draw_above");

        // Flap every frame until the ceiling kills the bird.
        k = 0;
        while (bif.dead !== 1'b1 && k < 80) begin
            bif.flap = 1'b1; cyc(); bif.flap = 1'b0;
            frame();
            k++;
        end
        if (k >= 80) begin
            n_checks++; n_errors++;
            $display("FAIL ceil_timeout: got no DEAD after %0d frames expected DEAD", k);
        end
        chk("ceil_y", 32'(bif.bird_y), 0);
        chk("ceil_dead", 32'(bif.dead), 1);
        chk("ceil_cnt", 32'(bif.flap_count), 39);
        pulse_start();
        chk("ceil_idle_y", 32'(bif.bird_y), 232);
        pulse_start();
        chk("ceil_play", 32'(bif.state), 1);
        chk("ceil_play_cnt", 32'(bif.flap_count), 0);
        cyc();

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
